// File: rtl/wb_pipe_reg.sv
// wb_pipe_reg: execute-to-writeback pipeline register.
// It has DEPTH stages of {Valid, RegWrite, Result, Rd}, with stall and flush.
// It also provides a youngest-first forwarding lookup across the in-flight
// stages and a saturating count of committed register writes.

// One pipeline stage. Flush has priority over Stall. A bubble is all zeros.
module wb_pipe_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              Stall,
  input  logic              vld_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] res_i,
  input  logic [ADDR_W-1:0] rd_i,
  output logic              vld_o,
  output logic              we_o,
  output logic [DATA_W-1:0] res_o,
  output logic [ADDR_W-1:0] rd_o
);
  logic              vld_q, vld_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [ADDR_W-1:0] rd_q, rd_d;

  // Next-state selection: flush clears, stall holds, otherwise load upstream.
  always_comb begin
    vld_d = vld_i;
    we_d  = we_i;
    res_d = res_i;
    rd_d  = rd_i;
    if (Flush) begin
      vld_d = 1'b0;
      we_d  = 1'b0;
      res_d = '0;
      rd_d  = '0;
    end else if (Stall) begin
      vld_d = vld_q;
      we_d  = we_q;
      res_d = res_q;
      rd_d  = rd_q;
    end
  end

  // Stage register. Reset is asynchronous and needs no clock edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_q <= 1'b0;
      we_q  <= 1'b0;
      res_q <= '0;
      rd_q  <= '0;
    end else begin
      vld_q <= vld_d;
      we_q  <= we_d;
      res_q <= res_d;
      rd_q  <= rd_d;
    end
  end

  assign vld_o = vld_q;
  assign we_o  = we_q;
  assign res_o = res_q;
  assign rd_o  = rd_q;
endmodule

module wb_pipe_reg #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int DEPTH       = 1,
  parameter int CNT_W       = 16,
  parameter int ZERO_REG_HW = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              in_Valid,
  input  logic              in_RegWrite,
  input  logic [DATA_W-1:0] in_Result,
  input  logic [ADDR_W-1:0] in_Rd,
  output logic              RegWrite_out,
  output logic [DATA_W-1:0] Result_out,
  output logic [ADDR_W-1:0] Rd_out,
  output logic              Valid_out,
  input  logic [ADDR_W-1:0] Rs_query,
  output logic              Fwd_hit,
  output logic [DATA_W-1:0] Fwd_data,
  output logic [CNT_W-1:0]  Commit_cnt
);
  // Chain index 0 is the masked input, and index k+1 is the output of stage k.
  logic [DEPTH:0]             vld_c;
  logic [DEPTH:0]             we_c;
  logic [DEPTH:0][DATA_W-1:0] res_c;
  logic [DEPTH:0][ADDR_W-1:0] rd_c;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fwd_hit_d;
  logic [DATA_W-1:0] fwd_data_d;

  // A non-valid incoming entry becomes an all-zero bubble.
  assign vld_c[0] = in_Valid;
  assign we_c[0]  = in_Valid & in_RegWrite;
  assign res_c[0] = in_Valid ? in_Result : '0;
  assign rd_c[0]  = in_Valid ? in_Rd     : '0;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    wb_pipe_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_stage (
      .Clk   (Clk),
      .Reset (Reset),
      .Flush (Flush),
      .Stall (Stall),
      .vld_i (vld_c[k]),
      .we_i  (we_c[k]),
      .res_i (res_c[k]),
      .rd_i  (rd_c[k]),
      .vld_o (vld_c[k+1]),
      .we_o  (we_c[k+1]),
      .res_o (res_c[k+1]),
      .rd_o  (rd_c[k+1])
    );
  end

  assign Valid_out    = vld_c[DEPTH];
  assign RegWrite_out = vld_c[DEPTH] & we_c[DEPTH];
  assign Result_out   = res_c[DEPTH];
  assign Rd_out       = rd_c[DEPTH];

  // Forwarding lookup uses the stage registers only. The scan runs from oldest
  // to youngest so that a later (younger) match overwrites an earlier one.
  always_comb begin
    fwd_hit_d  = 1'b0;
    fwd_data_d = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (vld_c[k+1] && we_c[k+1] && (rd_c[k+1] == Rs_query)) begin
        fwd_hit_d  = 1'b1;
        fwd_data_d = res_c[k+1];
      end
    end
    if ((ZERO_REG_HW != 0) && (Rs_query == '0)) begin
      fwd_hit_d  = 1'b0;
      fwd_data_d = '0;
    end
  end

  assign Fwd_hit  = fwd_hit_d;
  assign Fwd_data = fwd_data_d;

  // A commit happens when the final stage loads a valid write. The final stage
  // loads from chain index DEPTH-1. The counter saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (!Flush && !Stall && vld_c[DEPTH-1] && we_c[DEPTH-1] && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Commit counter register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign Commit_cnt = cnt_q;
endmodule

// File: doc/wb_pipe_reg.md
# wb_pipe_reg

Parametrised execute-to-writeback pipeline register for the 8-bit pipelined processor. It carries the register-write control, the ALU result and the destination register index through DEPTH register stages. Each stage has a valid bit, and the block supports stall and flush. It also drives a youngest-first forwarding lookup across all in-flight stages and a saturating count of committed register writes. It sits between the ALU output and the register-file write port, and feeds the forwarding mux.

## Interface
Parameters:
- DATA_W, 8, width of the result datapath
- ADDR_W, 3, width of the register index
- DEPTH, 1, number of register stages (1..4); 1 is the classic single EX/WB register
- CNT_W, 16, width of the commit counter
- ZERO_REG_HW, 0, if 1, register index 0 never produces a forwarding hit

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high reset
- Stall  in  1  hold all stages and the counter
- Flush  in  1  invalidate all stages at the next edge
- in_Valid  in  1  the incoming entry is a real instruction
- in_RegWrite  in  1  the incoming entry writes the register file
- in_Result  in  DATA_W  ALU result
- in_Rd  in  ADDR_W  destination register
- RegWrite_out  out  1  final stage Valid AND RegWrite (gated write enable)
- Result_out  out  DATA_W  final stage result
- Rd_out  out  ADDR_W  final stage destination
- Valid_out  out  1  final stage valid
- Rs_query  in  ADDR_W  source register to look up
- Fwd_hit  out  1  a matching in-flight write exists
- Fwd_data  out  DATA_W  result of the youngest matching entry; 0 when there is no hit
- Commit_cnt  out  CNT_W  number of writes committed to the final stage

## Operation
- Stage 0 loads from the in_* inputs. Stage k loads from stage k-1. Stage DEPTH-1 drives the *_out ports.
- Each stage holds {Valid, RegWrite, Result, Rd}.
- An invalid entry (bubble) always holds all-zero fields. When in_Valid=0, stage 0 loads all zeros regardless of the other in_* inputs.
- Priority at each edge: Reset > Flush > Stall > normal shift.
  - Flush: every stage becomes all-zero. The counter holds. Flush overrides Stall.
  - Stall (no Flush): every stage and the counter hold their values.
  - Normal: all stages shift by one.
- Forwarding (combinational from stage registers only, never from in_*):
  - A stage matches if Valid=1, RegWrite=1 and Rd==Rs_query.
  - Stage 0 has the highest priority, then stage 1, and so on.
  - When ZERO_REG_HW=1 and Rs_query==0, Fwd_hit=0.
- Commit counter:
  - Increments by 1 at each non-stalled, non-flushed edge where the final stage is loaded with Valid=1 and RegWrite=1.
  - Saturates at 2^CNT_W-1; it does not wrap.
- Reset clears all stages, all outputs and Commit_cnt to 0 immediately, with no clock needed.

## Timing
- Latency: an entry presented at edge n appears on *_out after edge n+DEPTH-1, i.e. DEPTH cycles including the capture edge. With DEPTH=1 it appears right after the capture edge.
- Stall held for s cycles adds s cycles of latency. No entry is duplicated or lost.
- Forwarding outputs and RegWrite_out settle in the same cycle as the stage registers (combinational path only).
- Reset asserted mid-operation discards every in-flight entry. After deassertion, the first capture edge loads stage 0 normally.
- A Flush in the same cycle as a valid in_* drops that incoming entry too.
- At saturation with an increment pending, the counter holds 2^CNT_W-1.

## Test plan
- DEPTH=1, apply Reset, then in {Valid=1, RegWrite=1, Result=0x5A, Rd=3} at edge 1 -> after edge 1: RegWrite_out=1, Result_out=0x5A, Rd_out=3, Commit_cnt=1.
- DEPTH=3, three back-to-back writes to Rd=2 with results 0x11, 0x22, 0x33, Rs_query=2 -> after the third edge, Fwd_hit=1 and Fwd_data=0x33 (youngest wins). Result_out=0x11.
- DEPTH=2, pipeline holding {0xAA, Rd=1} in both stages, assert Stall for 3 cycles while in_* changes -> all outputs are unchanged and Commit_cnt is unchanged. The first entry emerges 3 cycles later than without the stall.
- DEPTH=2, full pipeline, Flush and Stall asserted together -> after that edge, Valid_out=0, RegWrite_out=0, Result_out=0, Fwd_hit=0.
- ZERO_REG_HW=1, write Rd=0 with result 0x7F, Rs_query=0 -> Fwd_hit=0 and Fwd_data=0. RegWrite_out still reaches 1 at the output stage.
- CNT_W=2, five committed writes -> Commit_cnt reads 1, 2, 3, 3, 3. Then assert Reset asynchronously between edges -> all outputs and Commit_cnt go to 0 before the next edge.
